// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store initiator with sub-word read-modify-write and big-endian lanes.
module mem_access_ctrl #(
    parameter int WORD_LEN    = 32,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                reqValid,
    output logic                reqReady,
    input  logic                reqWrite,
    input  logic [1:0]          reqSize,
    input  logic                reqSigned,
    input  logic [WORD_LEN-1:0] reqAddress,
    input  logic [WORD_LEN-1:0] reqData,
    output logic                respValid,
    output logic                respErr,
    output logic [WORD_LEN-1:0] loadData,
    output logic                dmReadEn,
    output logic                dmWriteEn,
    output logic [WORD_LEN-1:0] dmAddress,
    output logic [WORD_LEN-1:0] dmDataIn,
    input  logic [WORD_LEN-1:0] dmDataOut
);
    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, ERR} state_t;
    state_t state, state_next;
    logic [WORD_LEN-1:0] addr_q, data_q, merge_q, load_ext, merged;
    logic [1:0] off_q, size_q;
    logic sgn_q, accept, misaligned;
    logic [4:0] byte_sh, half_sh;
    logic [7:0] rd_byte;
    logic [15:0] rd_half;
    always_comb begin
        accept = reqValid & reqReady;
        misaligned = CHECK_ALIGN && ((reqSize == 2'b01 && reqAddress[0]) ||
                                     (reqSize[1] && reqAddress[1:0] != 2'b00));
        // offset 0 is the most significant lane, hence the inverted offset
        byte_sh = {~off_q, 3'b000};
        half_sh = {~off_q[1], 4'b0000};
        rd_byte = 8'(dmDataOut >> byte_sh);
        rd_half = 16'(dmDataOut >> half_sh);
        load_ext = size_q == 2'b00 ? {{(WORD_LEN-8){sgn_q & rd_byte[7]}}, rd_byte} :
                   size_q == 2'b01 ? {{(WORD_LEN-16){sgn_q & rd_half[15]}}, rd_half} : dmDataOut;
        merged = size_q == 2'b00 ?
                 (dmDataOut & ~(WORD_LEN'(8'hFF) << byte_sh)) | (WORD_LEN'(data_q[7:0]) << byte_sh) :
                 (dmDataOut & ~(WORD_LEN'(16'hFFFF) << half_sh)) | (WORD_LEN'(data_q[15:0]) << half_sh);
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end
    always_comb begin
        state_next = state;
        reqReady   = state == IDLE;
        dmReadEn   = 1'b0;
        dmWriteEn  = 1'b0;
        dmAddress  = '0;
        dmDataIn   = '0;
        case (state)
            IDLE: if (accept) state_next = misaligned ? ERR : !reqWrite ? RD : reqSize[1] ? WR : RMW_RD;
            RD: begin
                dmReadEn   = !rst;
                dmAddress  = addr_q;
                state_next = IDLE;
            end
            WR: begin
                dmWriteEn  = !rst;
                dmAddress  = addr_q;
                dmDataIn   = dmWriteEn ? data_q : '0;
                state_next = IDLE;
            end
            RMW_RD: begin
                dmReadEn   = !rst;
                dmAddress  = addr_q;
                state_next = RMW_WR;
            end
            RMW_WR: begin
                dmWriteEn  = !rst;
                dmAddress  = addr_q;
                dmDataIn   = dmWriteEn ? merge_q : '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            respValid <= 1'b0;
            respErr   <= 1'b0;
            loadData  <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            merge_q   <= '0;
            off_q     <= '0;
            size_q    <= '0;
            sgn_q     <= 1'b0;
        end else begin
            respValid <= state == RD || state == WR || state == RMW_WR || state == ERR;
            respErr   <= state == ERR;
            if (accept) begin
                addr_q <= {reqAddress[WORD_LEN-1:2], 2'b00};
                off_q  <= reqAddress[1:0];
                size_q <= reqSize;
                sgn_q  <= reqSigned;
                data_q <= reqData;
            end
            if (state == RD) loadData <= load_ext;
            if (state == RMW_RD) merge_q <= merged;
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed self-checking bench with a simple combinational-read data memory.
module tb_mem_access_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic reqValid = 1'b0, reqReady, reqWrite = 1'b0, reqSigned = 1'b0;
    logic [1:0] reqSize = 2'b10;
    logic [31:0] reqAddress = '0, reqData = '0;
    logic respValid, respErr, dmReadEn, dmWriteEn;
    logic [31:0] loadData, dmAddress, dmDataIn, dmDataOut;
    logic [31:0] mem [1024];
    int n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.WORD_LEN(32), .CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqSize(reqSize), .reqSigned(reqSigned), .reqAddress(reqAddress), .reqData(reqData),
        .respValid(respValid), .respErr(respErr), .loadData(loadData), .dmReadEn(dmReadEn),
        .dmWriteEn(dmWriteEn), .dmAddress(dmAddress), .dmDataIn(dmDataIn), .dmDataOut(dmDataOut)
    );

    assign dmDataOut = mem[dmAddress[11:2]];
    always @(posedge clk) if (dmWriteEn) mem[dmAddress[11:2]] <= dmDataIn;

    task automatic drive(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] d);
        reqValid = 1'b1; reqWrite = w; reqSize = sz; reqSigned = sg; reqAddress = a; reqData = d;
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output int rd, output int wr,
                          output logic err, output logic [31:0] waddr);
        drive(w, sz, sg, a, d);
        lat = -1; rd = 0; wr = 0; err = 1'b0; waddr = '0;
        @(posedge clk);
        #1 reqValid = 1'b0;
        for (int k = 1; k <= 6 && lat < 0; k++) begin
            @(negedge clk);
            if (dmReadEn) rd++;
            if (dmWriteEn) begin wr++; waddr = dmAddress; end
            if (respValid) begin lat = k; err = respErr; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (reqReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", reqReady); end
        n_cmp++; if (respValid !== 1'b0) begin n_fail++; $display("FAIL reset_resp: got %b want 0", respValid); end
        n_cmp++; if (respErr !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", respErr); end
        n_cmp++; if (loadData !== 32'h0) begin n_fail++; $display("FAIL reset_load: got %h want 0", loadData); end
        n_cmp++; if ({dmReadEn, dmWriteEn} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b want 00", {dmReadEn, dmWriteEn}); end
        n_cmp++; if (dmAddress !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", dmAddress); end
        n_cmp++; if (dmDataIn !== 32'h0) begin n_fail++; $display("FAIL reset_din: got %h want 0", dmDataIn); end
    endtask

    task automatic test_word;
        int lat, rd, wr; logic err; logic [31:0] wa;
        do_req(1'b1, 2'b10, 1'b0, 32'h400, 32'hDEADBEEF, lat, rd, wr, err, wa);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL wst_latency: got %0d want 2", lat); end
        n_cmp++; if (wr !== 1 || rd !== 0) begin n_fail++; $display("FAIL wst_strobes: got rd=%0d wr=%0d want rd=0 wr=1", rd, wr); end
        n_cmp++; if (wa !== 32'h400) begin n_fail++; $display("FAIL wst_addr: got %h want 400", wa); end
        n_cmp++; if (mem[256] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wst_mem: got %h want deadbeef", mem[256]); end
        do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, lat, rd, wr, err, wa);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL wld_latency: got %0d want 2", lat); end
        n_cmp++; if (loadData !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wld_data: got %h want deadbeef", loadData); end
        n_cmp++; if (err !== 1'b0 || rd !== 1 || wr !== 0) begin n_fail++; $display("FAIL wld_flags: got err=%b rd=%0d wr=%0d want 0/1/0", err, rd, wr); end
    endtask

    task automatic test_byte_store;
        int lat, rd, wr; logic err; logic [31:0] wa;
        do_req(1'b1, 2'b00, 1'b0, 32'h402, 32'h0000005A, lat, rd, wr, err, wa);
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL bst_latency: got %0d want 3", lat); end
        n_cmp++; if (rd !== 1 || wr !== 1) begin n_fail++; $display("FAIL bst_strobes: got rd=%0d wr=%0d want 1/1", rd, wr); end
        n_cmp++; if (mem[256] !== 32'hDEAD5AEF) begin n_fail++; $display("FAIL bst_mem: got %h want dead5aef", mem[256]); end
        do_req(1'b1, 2'b01, 1'b0, 32'h40A, 32'hFFFF1234, lat, rd, wr, err, wa);
        n_cmp++; if (mem[258] !== 32'h00001234 || lat !== 3) begin n_fail++; $display("FAIL hst_mem: got %h lat %0d want 00001234 lat 3", mem[258], lat); end
    endtask

    task automatic test_loads;
        int lat, rd, wr; logic err; logic [31:0] wa;
        do_req(1'b0, 2'b00, 1'b1, 32'h400, 32'h0, lat, rd, wr, err, wa);
        n_cmp++; if (loadData !== 32'hFFFFFFDE) begin n_fail++; $display("FAIL lb_signed: got %h want ffffffde", loadData); end
        do_req(1'b0, 2'b00, 1'b0, 32'h400, 32'h0, lat, rd, wr, err, wa);
        n_cmp++; if (loadData !== 32'h000000DE) begin n_fail++; $display("FAIL lb_unsigned: got %h want 000000de", loadData); end
        do_req(1'b0, 2'b01, 1'b1, 32'h402, 32'h0, lat, rd, wr, err, wa);
        n_cmp++; if (loadData !== 32'h00005AEF) begin n_fail++; $display("FAIL lh_signed_pos: got %h want 00005aef", loadData); end
        do_req(1'b0, 2'b01, 1'b1, 32'h400, 32'h0, lat, rd, wr, err, wa);
        n_cmp++; if (loadData !== 32'hFFFFDEAD) begin n_fail++; $display("FAIL lh_signed_neg: got %h want ffffdead", loadData); end
        do_req(1'b0, 2'b00, 1'b1, 32'h403, 32'h0, lat, rd, wr, err, wa);
        n_cmp++; if (loadData !== 32'hFFFFFFEF) begin n_fail++; $display("FAIL lb_off3: got %h want ffffffef", loadData); end
        do_req(1'b0, 2'b00, 1'b0, 32'h401, 32'h0, lat, rd, wr, err, wa);
        n_cmp++; if (loadData !== 32'h000000AD) begin n_fail++; $display("FAIL lb_off1: got %h want 000000ad", loadData); end
        do_req(1'b0, 2'b11, 1'b1, 32'h400, 32'h0, lat, rd, wr, err, wa);
        n_cmp++; if (loadData !== 32'hDEAD5AEF) begin n_fail++; $display("FAIL lw_size3: got %h want dead5aef", loadData); end
    endtask

    task automatic test_misalign;
        int lat, rd, wr; logic err; logic [31:0] wa;
        do_req(1'b0, 2'b00, 1'b0, 32'h402, 32'h0, lat, rd, wr, err, wa);
        do_req(1'b0, 2'b01, 1'b0, 32'h401, 32'h0, lat, rd, wr, err, wa);
        n_cmp++; if (lat !== 2 || err !== 1'b1) begin n_fail++; $display("FAIL mis_half_resp: got lat=%0d err=%b want 2/1", lat, err); end
        n_cmp++; if (rd !== 0 || wr !== 0) begin n_fail++; $display("FAIL mis_half_strobes: got rd=%0d wr=%0d want 0/0", rd, wr); end
        n_cmp++; if (loadData !== 32'h0000005A) begin n_fail++; $display("FAIL mis_hold_load: got %h want 0000005a", loadData); end
        do_req(1'b1, 2'b10, 1'b0, 32'h402, 32'h12345678, lat, rd, wr, err, wa);
        n_cmp++; if (err !== 1'b1 || wr !== 0 || mem[256] !== 32'hDEAD5AEF) begin n_fail++; $display("FAIL mis_word_store: got err=%b wr=%0d mem=%h want 1/0/dead5aef", err, wr, mem[256]); end
        do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, lat, rd, wr, err, wa);
        n_cmp++; if (lat !== 2 || err !== 1'b0 || loadData !== 32'hDEAD5AEF) begin n_fail++; $display("FAIL mis_recover: got lat=%0d err=%b data=%h want 2/0/dead5aef", lat, err, loadData); end
    endtask

    task automatic test_reset_mid;
        int resp_seen = 0, wr_seen = 0;
        drive(1'b1, 2'b00, 1'b0, 32'h400, 32'h00000011);
        @(posedge clk);
        #1 reqValid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (dmWriteEn !== 1'b0) begin n_fail++; $display("FAIL rstmid_wen: got %b want 0", dmWriteEn); end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (respValid) resp_seen++;
            if (dmWriteEn) wr_seen++;
        end
        n_cmp++; if (resp_seen !== 0 || wr_seen !== 0) begin n_fail++; $display("FAIL rstmid_quiet: got resp=%0d wr=%0d want 0/0", resp_seen, wr_seen); end
        n_cmp++; if (reqReady !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", reqReady); end
        n_cmp++; if (mem[256] !== 32'hDEAD5AEF) begin n_fail++; $display("FAIL rstmid_mem: got %h want dead5aef", mem[256]); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] addrs [6] = '{32'h404, 32'h404, 32'h408, 32'h408, 32'h404, 32'h404};
        logic [31:0] datas [6] = '{32'h11111111, 32'h0, 32'h22222222, 32'h0, 32'h33333333, 32'h0};
        logic [31:0] want [3] = '{32'h11111111, 32'h22222222, 32'h33333333};
        int idx = 0, resp_n = 0, prev = -1, bad_gap = 0, rd = 0, wr = 0, bad_load = 0;
        logic rdy;
        drive(1'b1, 2'b10, 1'b0, addrs[0], datas[0]);
        for (int c = 0; c < 16; c++) begin
            rdy = reqReady;
            @(posedge clk);
            if (rdy && idx < 6) begin
                idx++;
                #1;
                if (idx < 6) drive(idx % 2 == 0, 2'b10, 1'b0, addrs[idx], datas[idx]);
                else reqValid = 1'b0;
            end
            @(negedge clk);
            if (dmReadEn) rd++;
            if (dmWriteEn) wr++;
            if (respValid) begin
                if (resp_n > 0 && c - prev != 2) bad_gap++;
                if (resp_n % 2 == 1 && resp_n < 6 && loadData !== want[resp_n / 2]) bad_load++;
                prev = c;
                resp_n++;
            end
        end
        n_cmp++; if (resp_n !== 6 || bad_gap !== 0) begin n_fail++; $display("FAIL b2b_resp: got count=%0d bad_gaps=%0d want 6/0", resp_n, bad_gap); end
        n_cmp++; if (rd !== 3 || wr !== 3) begin n_fail++; $display("FAIL b2b_strobes: got rd=%0d wr=%0d want 3/3", rd, wr); end
        n_cmp++; if (bad_load !== 0) begin n_fail++; $display("FAIL b2b_loads: got %0d wrong want 0", bad_load); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        test_reset;
        test_word;
        test_byte_store;
        test_loads;
        test_misalign;
        test_reset_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
